// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the hazard controller (slave).
// Carries hazard sources from ID/EX/MEM/WB plus the stage hold/squash controls and statistics.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       rs1_id;
  logic [4:0]       rs2_id;
  logic             use_rs1_id;
  logic             use_rs2_id;
  logic [4:0]       rd_ex;
  logic             RWrEn_ex;
  logic             MemToReg_ex;
  logic             redirect_mem;
  logic             dmem_req_mem;
  logic             dmem_ready;
  logic             halt_wb;

  logic             WEN_pc;
  logic             WEN_if_id;
  logic             WEN_id_ex;
  logic             WEN_ex_mem;
  logic             WEN_mem_wb;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             flush_ex_mem;
  logic             halted;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, RWrEn_ex, MemToReg_ex,
           redirect_mem, dmem_req_mem, dmem_ready, halt_wb,
    input  WEN_pc, WEN_if_id, WEN_id_ex, WEN_ex_mem, WEN_mem_wb,
           flush_if_id, flush_id_ex, flush_ex_mem, halted, mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  rs1_id, rs2_id, use_rs1_id, use_rs2_id, rd_ex, RWrEn_ex, MemToReg_ex,
           redirect_mem, dmem_req_mem, dmem_ready, halt_wb,
    output WEN_pc, WEN_if_id, WEN_id_ex, WEN_ex_mem, WEN_mem_wb,
           flush_if_id, flush_id_ex, flush_ex_mem, halted, mem_timeout, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stage hold (WEN) and squash (flush) generation for load-use,
// dmem wait states, MEM-stage redirects and halt, with stall/flush statistics.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   RUN      | pipeline advancing; halt/mem-wait/redirect/load-use evaluated
//   MEM_WAIT | whole pipeline frozen until dmem_ready or wait timeout
//   HALTED   | whole pipeline frozen after halt retire or timeout; RST only exit
module pipeline_hazard_ctrl #(
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 32
) (
  input logic                    CLK,
  input logic                    RST,
  pipeline_hazard_ctrl_if.slave  hz
);

  localparam int WCW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic advance;
  logic redirect_taken;
  logic hold_all;
  logic wen_pc, wen_if_id, wen_id_ex, wen_ex_mem, wen_mem_wb;
  logic fl_if_id, fl_id_ex, fl_ex_mem;

  always_comb begin
    load_use = hz.MemToReg_ex & hz.RWrEn_ex & (hz.rd_ex != 5'd0) &
               ((hz.use_rs1_id & (hz.rs1_id == hz.rd_ex)) |
                (hz.use_rs2_id & (hz.rs2_id == hz.rd_ex)));
  end

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    mem_timeout_d  = mem_timeout_q;
    advance        = 1'b0;
    hold_all       = 1'b0;
    redirect_taken = 1'b0;
    wen_pc         = 1'b0;
    wen_if_id      = 1'b0;
    wen_id_ex      = 1'b0;
    wen_ex_mem     = 1'b0;
    wen_mem_wb     = 1'b0;
    fl_if_id       = 1'b0;
    fl_id_ex       = 1'b0;
    fl_ex_mem      = 1'b0;

    case (state_q)
      RUN: begin
        if (hz.halt_wb) begin
          hold_all = 1'b1;
          state_d  = HALTED;
        end else if (hz.dmem_req_mem & ~hz.dmem_ready) begin
          hold_all   = 1'b1;
          wait_cnt_d = WCW'(1);
          state_d    = MEM_WAIT;
        end else begin
          advance = 1'b1;
        end
      end
      MEM_WAIT: begin
        // WB is frozen on the same instruction here, so halt_wb is deliberately ignored.
        if (hz.dmem_ready) begin
          advance    = 1'b1;
          wait_cnt_d = '0;
          state_d    = RUN;
        end else begin
          hold_all = 1'b1;
          if (wait_cnt_q == WCW'(WAIT_MAX)) begin
            mem_timeout_d = 1'b1;
            state_d       = HALTED;
          end else begin
            wait_cnt_d = wait_cnt_q + WCW'(1);
          end
        end
      end
      HALTED: begin
        hold_all = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (advance) begin
      // A redirect squashes the ID instruction, so a load-use match on it is moot.
      if (hz.redirect_mem) begin
        redirect_taken = 1'b1;
        fl_if_id       = 1'b1;
        fl_id_ex       = 1'b1;
        fl_ex_mem      = 1'b1;
      end else if (load_use) begin
        wen_pc    = 1'b1;
        wen_if_id = 1'b1;
        fl_id_ex  = 1'b1;
      end
    end

    if (hold_all) begin
      wen_pc     = 1'b1;
      wen_if_id  = 1'b1;
      wen_id_ex  = 1'b1;
      wen_ex_mem = 1'b1;
      wen_mem_wb = 1'b1;
    end

    if (!RST) begin
      wen_pc         = 1'b0;
      wen_if_id      = 1'b0;
      wen_id_ex      = 1'b0;
      wen_ex_mem     = 1'b0;
      wen_mem_wb     = 1'b0;
      fl_if_id       = 1'b0;
      fl_id_ex       = 1'b0;
      fl_ex_mem      = 1'b0;
      redirect_taken = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (wen_pc && (state_q != HALTED)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    flush_cnt_d = flush_cnt_q;
    if (redirect_taken) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Same edge as the stage registers this controller steers.
  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign hz.WEN_pc       = wen_pc;
  assign hz.WEN_if_id    = wen_if_id;
  assign hz.WEN_id_ex    = wen_id_ex;
  assign hz.WEN_ex_mem   = wen_ex_mem;
  assign hz.WEN_mem_wb   = wen_mem_wb;
  assign hz.flush_if_id  = fl_if_id;
  assign hz.flush_id_ex  = fl_id_ex;
  assign hz.flush_ex_mem = fl_ex_mem;
  assign hz.halted       = (state_q == HALTED);
  assign hz.mem_timeout  = mem_timeout_q;
  assign hz.stall_cnt    = stall_cnt_q;
  assign hz.flush_cnt    = flush_cnt_q;

endmodule
